if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the pipelined LC-3b datapath. Holds the fetch PC, runs the instruction-memory read handshake, and presents each fetched instruction word with its PC to decode, where the IR drives the control ROM. It absorbs decode stalls with a one-entry buffer and honours PC redirects (branch, JMP, JSR, TRAP) from later stages. Outstanding memory reads cannot be aborted: redirected reads are drained and their data discarded.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch PC loaded on reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  decode cannot accept; output register holds
- redirect  in  1  PC change from a later stage; flushes fetch state
- redirect_pc  in  16  new fetch PC, valid with redirect
- imem_address  out  16  instruction-memory address
- imem_read  out  1  instruction-memory read request
- imem_resp  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  16  instruction word
- valid_out  out  1  ir_out/pc_out hold a real instruction
- ir_out  out  16  instruction word (lc3b_word) to decode/control ROM
- pc_out  out  16  address of ir_out
- pc_plus2_out  out  16  pc_out + 2, mod 2^16

## Operation
- Registers: pc (next fetch address), drain_addr, buffer {ir, pc}, output {valid, ir, pc}, state.
- States: FETCH (request pc), BUFFERED (word held, no request), DRAIN (redirected request outstanding).
- FETCH: imem_read=1, imem_address=pc.
  - resp and (!valid_out or !stall): output <= {1, imem_rdata, pc}; pc <= pc+2; stay FETCH.
  - resp and valid_out and stall: buffer <= {imem_rdata, pc}; pc <= pc+2; go BUFFERED.
  - no resp: hold.
- BUFFERED: imem_read=0. When !stall: output <= {1, buffer}; go FETCH.
- DRAIN: imem_read=1, imem_address=drain_addr. On resp: data discarded; go FETCH.
- Output register with !stall and nothing captured: valid_out <= 0.
- Redirect has priority over all of the above, in every state, regardless of stall:
  - pc <= redirect_pc; valid_out <= 0; buffer discarded.
  - FETCH without resp: drain_addr <= pc; go DRAIN.
  - FETCH with resp: data discarded; stay FETCH.
  - BUFFERED: go FETCH.
  - DRAIN: stay DRAIN; drain_addr unchanged.
- Arithmetic is 16-bit and wraps: pc 16'hFFFE advances to 16'h0000.
- redirect_pc[0] is passed through unmodified.

## Timing
- Reset values: state=FETCH, pc=RESET_PC, valid_out=0, ir_out=0, pc_out=0, pc_plus2_out=2, imem_read=1 (the first cycle after reset), imem_address=RESET_PC.
- Reset mid-request abandons any outstanding read; the memory model is reset by the same rst.
- Latency: imem_resp in cycle N gives valid_out/ir_out in cycle N+1.
  - Next request address (pc+2) appears in cycle N+1.
  - Throughput is one instruction per cycle with single-cycle memory.
- imem_address and imem_read are stable from assertion until imem_resp.
- Redirect in cycle N:
  - valid_out=0 in N+1.
  - Fetch of redirect_pc starts in N+1 if no read was outstanding.
  - Otherwise it starts the cycle after the drained imem_resp.
- No instruction is lost or duplicated across a stall. The buffered word is presented in the first cycle after stall deasserts.

## Configuration
- IF_PERF_CNT_EN
  - Defined: adds outputs perf_fetched (16, count of words written to the output register) and perf_stall (16, cycles with stall && valid_out).
  - Counters reset to 0, saturate at 16'hFFFF, and do not count discarded words.
  - Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset, then single-cycle memory returning 16'h1261 at 0x0000 and 16'h5020 at 0x0002 -> valid_out cycles 1,2 with pc_out 0x0000/0x0002, pc_plus2_out 0x0002/0x0004.
- Stall held 3 cycles while resp arrives for 0x0004 -> output stays at the 0x0002 word. State goes BUFFERED with imem_read=0. On release, the 0x0004 word appears next cycle; no gap or duplicate.
- Redirect to 0x3000 while a 4-cycle read of 0x0006 is outstanding -> imem_address stays 0x0006 until resp, that data is dropped, then a read of 0x3000 is issued. valid_out=0 throughout.
- Redirect in the same cycle as resp and stall -> valid_out=0 next cycle; the next request is to redirect_pc.
- pc=16'hFFFE fetch -> pc_plus2_out=16'h0000; next request address 16'h0000.
- With IF_PERF_CNT_EN, 10 fetches, 4 stalled cycles, 1 drained word -> perf_fetched=10, perf_stall=4.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage : instruction-fetch stage of the pipelined LC-3b datapath.
//
// Holds the fetch PC, runs the instruction-memory read handshake and presents
// each fetched word with its PC to decode. A one-entry buffer absorbs decode
// stalls. Redirects from later stages flush fetch state. An in-flight memory
// read cannot be aborted, so it is drained and its data dropped.
//
// Optional feature macro: IF_PERF_CNT_EN adds saturating performance counters.
//
// Parameters:
//   RESET_PC      fetch PC loaded on reset
// Ports:
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   stall         decode cannot accept; output register holds
//   redirect      PC change from a later stage
//   redirect_pc   new fetch PC (bit 0 passed through unmodified)
//   imem_address  instruction-memory address
//   imem_read     instruction-memory read request
//   imem_resp     read complete, imem_rdata valid this cycle
//   imem_rdata    instruction word from memory
//   valid_out     ir_out/pc_out hold a real instruction
//   ir_out        instruction word to decode / control ROM
//   pc_out        address of ir_out
//   pc_plus2_out  pc_out + 2 (wraps)
//   perf_fetched  (IF_PERF_CNT_EN) words written to the output register
//   perf_stall    (IF_PERF_CNT_EN) cycles with stall && valid_out
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] imem_address,
  output logic        imem_read,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  output logic        valid_out,
  output logic [15:0] ir_out,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2_out
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetched,
  output logic [15:0] perf_stall
`endif
);

  typedef enum logic [1:0] {FETCH, BUFFERED, DRAIN} state_t;

  function automatic logic [15:0] inc2(input logic [15:0] a);
    return a + 16'd2;
  endfunction

  state_t      state, state_n;
  logic [15:0] pc, pc_n;
  logic [15:0] drain_addr;
  logic [15:0] buf_ir_p0, buf_pc_p0;
  logic        vld_n;
  logic        load_out, buf_load, drain_load;
  logic [15:0] out_ir_n, out_pc_n;

  assign imem_read    = (state != BUFFERED);
  assign imem_address = (state == DRAIN) ? drain_addr : pc;
  assign pc_plus2_out = inc2(pc_out);

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    // A stalled output holds; an accepted one empties unless refilled below.
    vld_n      = stall ? valid_out : 1'b0;
    load_out   = 1'b0;
    buf_load   = 1'b0;
    drain_load = 1'b0;
    out_ir_n   = imem_rdata;
    out_pc_n   = pc;
    if (redirect) begin
      pc_n  = redirect_pc;
      vld_n = 1'b0;
      case (state)
        FETCH: begin
          // Read still in flight: remember its address so it can be drained.
          if (!imem_resp) begin
            drain_load = 1'b1;
            state_n    = DRAIN;
          end
        end
        BUFFERED: state_n = FETCH;
        DRAIN:    state_n = DRAIN;
        default:  state_n = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          if (imem_resp) begin
            pc_n = inc2(pc);
            if (!valid_out || !stall) begin
              load_out = 1'b1;
              vld_n    = 1'b1;
            end else begin
              buf_load = 1'b1;
              state_n  = BUFFERED;
            end
          end
        end
        BUFFERED: begin
          if (!stall) begin
            load_out = 1'b1;
            vld_n    = 1'b1;
            out_ir_n = buf_ir_p0;
            out_pc_n = buf_pc_p0;
            state_n  = FETCH;
          end
        end
        DRAIN: begin
          if (imem_resp) state_n = FETCH;
        end
        default: state_n = FETCH;
      endcase
    end
  end

  // Control state and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      valid_out <= 1'b0;
      ir_out    <= 16'h0000;
      pc_out    <= 16'h0000;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      valid_out <= vld_n;
      if (load_out) begin
        ir_out <= out_ir_n;
        pc_out <= out_pc_n;
      end
    end
  end

  // Stall buffer and drain address (data only)
  always_ff @(posedge clk) begin
    if (drain_load) drain_addr <= pc;
    if (buf_load) begin
      buf_ir_p0 <= imem_rdata;
      buf_pc_p0 <= pc;
    end
  end

`ifdef IF_PERF_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched <= 16'h0000;
      perf_stall   <= 16'h0000;
    end else begin
      if (load_out)           perf_fetched <= sat_inc(perf_fetched);
      if (stall && valid_out) perf_stall   <= sat_inc(perf_stall);
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] imem_address;
  logic        imem_read;
  logic        imem_resp = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        valid_out;
  logic [15:0] ir_out, pc_out, pc_plus2_out;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetched, perf_stall;
`endif

  if_stage #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_address(imem_address),
    .imem_read(imem_read), .imem_resp(imem_resp), .imem_rdata(imem_rdata),
    .valid_out(valid_out), .ir_out(ir_out), .pc_out(pc_out),
    .pc_plus2_out(pc_plus2_out)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory contents as a pure function of address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1261;
    if (a == 16'h0002) return 16'h5020;
    return (a * 16'd40503) ^ 16'hC3A5;
  endfunction

  // Scoreboard: redirect targets tagged with the cycle they were issued.
  typedef struct {
    int          tag;
    logic [15:0] pc;
  } redir_t;
  redir_t rq[$];

  // Memory model: latency fixed_lat (>=0) or random 0..3 when negative.
  int          fixed_lat = 0;
  logic        mbusy = 1'b0;
  logic [15:0] maddr = 16'h0000;
  int          mcnt = 0;
  always begin
    @(negedge clk);
    #1;
    imem_resp  = 1'b0;
    imem_rdata = 16'($urandom);
    if (rst) begin
      mbusy = 1'b0;
    end else if (imem_read) begin
      if (!mbusy) begin
        mbusy = 1'b1;
        maddr = imem_address;
        mcnt  = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
      end else begin
        check("addr_stable", imem_address, maddr);
      end
      if (mcnt == 0) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(maddr);
        mbusy      = 1'b0;
      end else begin
        mcnt--;
      end
    end
  end

  // Monitor: every word decode accepts must continue the expected PC stream.
  logic [15:0] exp_pc = 16'h0000;
  int          accepted = 0;
  logic        prev_redirect = 1'b0, prev_valid = 1'b0, prev_stall = 1'b0;
  int          m_fetch = 0, m_stall = 0, m_stall_prev = 0;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      exp_pc = 16'h0000;
      rq.delete();
      prev_redirect = 1'b0; prev_valid = 1'b0; prev_stall = 1'b0;
      m_fetch = 0; m_stall = 0; m_stall_prev = 0;
    end else begin
      if (prev_redirect) check("flush_valid", {15'd0, valid_out}, 16'd0);
      if (valid_out && (!prev_valid || !prev_stall)) m_fetch++;
      m_stall_prev = m_stall;
      if (stall && valid_out) m_stall++;
      if (valid_out && !stall) begin
        while (rq.size() > 0 && rq[0].tag < cyc) begin
          exp_pc = rq[0].pc;
          void'(rq.pop_front());
        end
        check("pc_out", pc_out, exp_pc);
        check("ir_out", ir_out, mem_word(exp_pc));
        check("pc_plus2_out", pc_plus2_out, exp_pc + 16'd2);
        exp_pc = exp_pc + 16'd2;
        accepted++;
      end
      prev_redirect = redirect;
      prev_valid    = valid_out;
      prev_stall    = stall;
    end
  end

  task automatic step(input logic s, input logic r, input logic [15:0] rp);
    @(negedge clk);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    if (r) rq.push_back('{tag: cyc, pc: rp});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 16'h0);
    // w0: first cycle out of reset
    step(1'b0, 1'b0, 16'h0); rst = 1'b0; #3;
    check("rst_valid", {15'd0, valid_out}, 16'd0);
    check("rst_ir", ir_out, 16'h0000);
    check("rst_pc_out", pc_out, 16'h0000);
    check("rst_pc_plus2", pc_plus2_out, 16'h0002);
    check("rst_imem_read", {15'd0, imem_read}, 16'd1);
    check("rst_imem_addr", imem_address, 16'h0000);
    // w1, w2: single-cycle memory, back-to-back words
    step(1'b0, 1'b0, 16'h0); #3;
    check("w1_valid", {15'd0, valid_out}, 16'd1);
    check("w1_pc", pc_out, 16'h0000);
    check("w1_ir", ir_out, 16'h1261);
    check("w1_pc2", pc_plus2_out, 16'h0002);
    step(1'b1, 1'b0, 16'h0); #3;
    check("w2_pc", pc_out, 16'h0002);
    check("w2_ir", ir_out, 16'h5020);
    check("w2_pc2", pc_plus2_out, 16'h0004);
    // stall for three cycles while 0x0004 arrives
    step(1'b1, 1'b0, 16'h0); #3;
    check("stall1_pc", pc_out, 16'h0002);
    check("stall1_read", {15'd0, imem_read}, 16'd0);
    step(1'b1, 1'b0, 16'h0); #3;
    check("stall2_pc", pc_out, 16'h0002);
    check("stall2_read", {15'd0, imem_read}, 16'd0);
    step(1'b0, 1'b0, 16'h0); #3;
    check("release_pc", pc_out, 16'h0002);
    check("release_valid", {15'd0, valid_out}, 16'd1);
    fixed_lat = 3;
    step(1'b0, 1'b0, 16'h0); #3;
    check("buffered_pc", pc_out, 16'h0004);
    check("buffered_ir", ir_out, mem_word(16'h0004));
    check("req6_addr", imem_address, 16'h0006);
    // redirect to 0x3000 while the 0x0006 read is outstanding
    step(1'b0, 1'b1, 16'h3000); #3;
    check("drain_addr0", imem_address, 16'h0006);
    step(1'b0, 1'b0, 16'h0); #3;
    check("drain_addr1", imem_address, 16'h0006);
    check("drain_read", {15'd0, imem_read}, 16'd1);
    check("drain_valid1", {15'd0, valid_out}, 16'd0);
    step(1'b0, 1'b0, 16'h0); #3;
    check("drain_addr2", imem_address, 16'h0006);
    check("drain_resp", {15'd0, imem_resp}, 16'd1);
    fixed_lat = 0;
    step(1'b0, 1'b0, 16'h0); #3;
    check("redir_addr", imem_address, 16'h3000);
    check("redir_valid", {15'd0, valid_out}, 16'd0);
    // redirect together with resp and stall
    step(1'b1, 1'b1, 16'h4000); #3;
    check("w3000_pc", pc_out, 16'h3000);
    check("w3000_valid", {15'd0, valid_out}, 16'd1);
    step(1'b0, 1'b1, 16'hFFFE); #3;
    check("rsr_valid", {15'd0, valid_out}, 16'd0);
    check("rsr_addr", imem_address, 16'h4000);
    // wrap at 0xFFFE
    step(1'b0, 1'b0, 16'h0); #3;
    check("wrap_req", imem_address, 16'hFFFE);
    step(1'b0, 1'b0, 16'h0); #3;
    check("wrap_pc", pc_out, 16'hFFFE);
    check("wrap_pc2", pc_plus2_out, 16'h0000);
    check("wrap_next_addr", imem_address, 16'h0000);
    // randomized traffic
    fixed_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, 16'($urandom));
    end
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 16'h0);
    #3;
    check("progress", {15'd0, accepted > 300}, 16'd1);
`ifdef IF_PERF_CNT_EN
    check("perf_fetched", perf_fetched, m_fetch[15:0]);
    check("perf_stall", perf_stall, m_stall_prev[15:0]);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
